if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction fetch queue between the fetch stage and decode. Captures every valid fetched instruction (PC, PC+4, IR) into a small circular FIFO, presents the oldest entry to decode, and decouples decode stalls from fetch. Asserts a full/stall signal back to fetch and discards all buffered entries on a taken branch from execute.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, width of PC, NPC and IR fields

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- if_PC_in  in  XLEN  PC of the fetched instruction
- if_NPC_in  in  XLEN  PC+4 of the fetched instruction
- if_IR_in  in  XLEN  fetched instruction word
- if_valid_inst_in  in  1  fetch offers a valid instruction this cycle
- ex_take_branch_out  in  1  taken branch from execute; flushes the queue
- id_stall  in  1  decode cannot accept an instruction this cycle
- fq_PC_out  out  XLEN  PC of the head entry
- fq_NPC_out  out  XLEN  NPC of the head entry
- fq_IR_out  out  XLEN  IR of the head entry
- fq_valid_inst_out  out  1  head entry is valid; outputs are garbage when low
- fq_stall_out  out  1  queue full; fetch must hold its PC
- fq_count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries of {PC, NPC, IR}, write pointer, read pointer, occupancy count. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: if_valid_inst_in && !fq_stall_out && !ex_take_branch_out. Writes the entry at the write pointer, then increments it.
- Pop: fq_valid_inst_out && !id_stall && !ex_take_branch_out. Increments the read pointer.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- fq_valid_inst_out = (fq_count != 0). Data outputs are read combinationally from the entry at the read pointer.
- fq_stall_out = (fq_count == DEPTH). It is derived from registered count only. While full, a push is refused even if a pop happens in the same cycle; there is no combinational path from id_stall to fq_stall_out.
- Flush: ex_take_branch_out high clears both pointers and the count at the next edge. Any same-cycle push or pop is ignored. Entry contents are left stale.
- Empty: a pop cannot occur. id_stall is don't-care.

## Timing
- Reset values: pointers 0, fq_count 0, fq_valid_inst_out 0, fq_stall_out 0. Data outputs reflect entry 0 and are undefined.
- Reset asserted mid-operation discards all entries asynchronously. The first push is accepted on the first rising edge after deassertion.
- Latency: an instruction pushed at edge N appears on the outputs after edge N (1 cycle) when the queue was empty.
- Throughput: one push and one pop per cycle sustained. At occupancy 1..DEPTH-1, push and pop in the same cycle keep the count constant.
- Flush takes effect at the edge where ex_take_branch_out is sampled high. The cycle after, fq_valid_inst_out=0 and fq_stall_out=0. The redirected fetch is pushed at the following edge.

## Configuration
- FQ_BYPASS_EN defined:
  - When the count is 0, if_valid_inst_in=1, id_stall=0 and no flush, the incoming instruction drives the fq_* data outputs and fq_valid_inst_out combinationally in the same cycle, and is not written (0-cycle latency).
  - If id_stall=1 in that case, a normal push occurs.
- FQ_BYPASS_EN undefined: no input-to-output combinational path; latency is always at least 1 cycle.

## Structure
- Package fq_pkg: typedef fetch_entry_t (packed struct: PC, NPC, IR, each XLEN) and constant FQ_DEFAULT_DEPTH=4.
- One sub-module, fq_storage: DEPTH x fetch_entry_t register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). Pointer, count, flush and bypass logic stay in if_fetch_queue.

## Test plan
- Reset: hold rst=0 mid-stream with 3 entries queued -> count=0, valid=0, stall=0 immediately. After release, push PC=0x0 -> head PC=0x0, NPC=0x4 next cycle.
- Fill: id_stall=1, push PCs 0x0,0x4,0x8,0xC -> count=4, stall=1. A fifth push of 0x10 is refused; head stays 0x0.
- Drain/wrap: from full, id_stall=0 with continuous pushes 0x10,0x14,... -> head sequence 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates across pointer wrap.
- Simultaneous: at count=2, push and pop in the same cycle -> count stays 2 and order is preserved. At count=4 with a pop, the push is refused and count=3.
- Flush: count=3, ex_take_branch_out=1 with if_valid_inst_in=1 -> next cycle count=0, valid=0. A push of target 0x40 then appears as head.
- Bypass (FQ_BYPASS_EN): empty queue, push 0x20, id_stall=0 -> fq_PC_out=0x20 and valid=1 in the same cycle, count stays 0. Without the macro, it appears one cycle later with count=1.

Source files
------------

// File: rtl/fq_pkg.sv
// rtl/fq_pkg.sv - shared types and defaults for the instruction fetch queue
package fq_pkg;
  localparam int FQ_DEFAULT_DEPTH = 4;
  localparam int FQ_XLEN = 32;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] npc;
    logic [FQ_XLEN-1:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH-entry register array, one write port, async read port
module fq_storage
  import fq_pkg::*;
#(
  parameter int  DEPTH   = FQ_DEFAULT_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  // Entries are deliberately unreset; flush and reset only move pointers.
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch-to-decode circular FIFO with flush and stall
// Optional same-cycle empty-queue bypass enabled by defining FQ_BYPASS_EN.
module if_fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH = FQ_DEFAULT_DEPTH,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          if_PC_in,
  input  logic [XLEN-1:0]          if_NPC_in,
  input  logic [XLEN-1:0]          if_IR_in,
  input  logic                     if_valid_inst_in,
  input  logic                     ex_take_branch_out,
  input  logic                     id_stall,
  output logic [XLEN-1:0]          fq_PC_out,
  output logic [XLEN-1:0]          fq_NPC_out,
  output logic [XLEN-1:0]          fq_IR_out,
  output logic                     fq_valid_inst_out,
  output logic                     fq_stall_out,
  output logic [$clog2(DEPTH):0]   fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, bypass, not_empty;
  entry_t        wdata, head;

  assign not_empty    = (count != '0);
  assign fq_stall_out = (count == FULL_COUNT);
  assign fq_count     = count;

`ifdef FQ_BYPASS_EN
  // Empty queue and decode ready: hand the fetched instruction straight through.
  assign bypass = !not_empty && if_valid_inst_in && !id_stall && !ex_take_branch_out;
`else
  assign bypass = 1'b0;
`endif

  assign push = if_valid_inst_in && !fq_stall_out && !ex_take_branch_out && !bypass;
  assign pop  = not_empty && !id_stall && !ex_take_branch_out;

  assign wdata = '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in};

  fq_storage #(.DEPTH(DEPTH), .entry_t(entry_t)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ex_take_branch_out) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  assign fq_valid_inst_out = not_empty || bypass;
  assign fq_PC_out         = bypass ? if_PC_in  : head.pc;
  assign fq_NPC_out        = bypass ? if_NPC_in : head.npc;
  assign fq_IR_out         = bypass ? if_IR_in  : head.ir;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue (DEPTH=4, XLEN=32)
module tb_if_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_PC_in, if_NPC_in, if_IR_in;
  logic        if_valid_inst_in, ex_take_branch_out, id_stall;
  logic [31:0] fq_PC_out, fq_NPC_out, fq_IR_out;
  logic        fq_valid_inst_out, fq_stall_out;
  logic [2:0]  fq_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] next_pc;
  logic        acc;

  if_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .if_PC_in           (if_PC_in),
    .if_NPC_in          (if_NPC_in),
    .if_IR_in           (if_IR_in),
    .if_valid_inst_in   (if_valid_inst_in),
    .ex_take_branch_out (ex_take_branch_out),
    .id_stall           (id_stall),
    .fq_PC_out          (fq_PC_out),
    .fq_NPC_out         (fq_NPC_out),
    .fq_IR_out          (fq_IR_out),
    .fq_valid_inst_out  (fq_valid_inst_out),
    .fq_stall_out       (fq_stall_out),
    .fq_count           (fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive, check pre-edge outputs, advance the model.
  task automatic step(input logic vin, input logic [31:0] pc, input logic idst,
                      input logic br, output logic accepted);
    int   n;
    logic byp, do_pop, do_push;
    if_valid_inst_in   = vin;
    if_PC_in           = pc;
    if_NPC_in          = pc + 32'd4;
    if_IR_in           = ir_of(pc);
    id_stall           = idst;
    ex_take_branch_out = br;
    #2;
    n   = sb.size();
    byp = BYP && (n == 0) && vin && !idst && !br;
    chk("count", 32'(fq_count), 32'(n));
    chk("stall", 32'(fq_stall_out), 32'(n == DEPTH));
    if (byp) begin
      chk("byp_valid", 32'(fq_valid_inst_out), 32'd1);
      chk("byp_pc", fq_PC_out, pc);
      chk("byp_npc", fq_NPC_out, pc + 32'd4);
    end else if (n > 0) begin
      chk("valid", 32'(fq_valid_inst_out), 32'd1);
      chk("head_pc", fq_PC_out, sb[0]);
      chk("head_npc", fq_NPC_out, sb[0] + 32'd4);
      chk("head_ir", fq_IR_out, ir_of(sb[0]));
    end else begin
      chk("valid", 32'(fq_valid_inst_out), 32'd0);
    end
    @(posedge clk);
    accepted = 1'b0;
    if (br) begin
      sb.delete();
    end else begin
      do_pop  = (n > 0) && !idst;
      do_push = vin && (n < DEPTH) && !byp;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(pc);
      accepted = do_push || byp;
    end
    @(negedge clk);
  endtask

  task automatic feed(input int cycles, input logic idst);
    logic a;
    for (int i = 0; i < cycles; i++) begin
      step(1'b1, next_pc, idst, 1'b0, a);
      if (a) next_pc += 32'd4;
    end
  endtask

  initial begin
    rst = 1'b0;
    if_valid_inst_in = 1'b0; ex_take_branch_out = 1'b0; id_stall = 1'b0;
    if_PC_in = '0; if_NPC_in = '0; if_IR_in = '0;
    #2;
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_valid", 32'(fq_valid_inst_out), 32'd0);
    chk("rst_stall", 32'(fq_stall_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Queue three entries, then pull reset asynchronously mid-cycle.
    next_pc = 32'h0;
    feed(3, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(fq_count), 32'd0);
    chk("async_rst_valid", 32'(fq_valid_inst_out), 32'd0);
    chk("async_rst_stall", 32'(fq_stall_out), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;

    // Fill to full under decode stall; extra offers are refused.
    next_pc = 32'h0;
    feed(4, 1'b1);
    feed(2, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Drain with continuous pushes across pointer wrap.
    feed(10, 1'b0);

    // Same-cycle push and pop at count 2, then at full.
    step(1'b1, 32'h0, 1'b1, 1'b1, acc);
    next_pc = 32'h100;
    feed(2, 1'b1);
    feed(3, 1'b0);
    feed(2, 1'b1);
    feed(1, 1'b0);

    // Flush at count 3 with a concurrent valid fetch, then redirect to 0x40.
    step(1'b1, next_pc, 1'b0, 1'b1, acc);
    step(1'b1, 32'h40, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Empty queue with decode ready: bypass build forwards, default build buffers.
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
    step(1'b1, 32'h20, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
